// File: rtl/mdu_ctrl.sv
// Iterative multiply/divide unit: 32-step shift-add multiply and restoring divide
// with sign fix-up, plus the architectural HI/LO registers and MTHI/MTLO writes.
`ifndef WORD_WIDTH
`define WORD_WIDTH 32
`endif

module mdu_ctrl #(
    parameter int W     = `WORD_WIDTH,
    parameter int STEPS = W
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [2:0]   mdu_op,
    input  logic [W-1:0] op1,
    input  logic [W-1:0] op2,
    input  logic         flush,
    output logic         busy,
    output logic         done,
    output logic [W-1:0] hi,
    output logic [W-1:0] lo
);

    localparam int CW = $clog2(STEPS) + 1;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        FIX
    } state_t;

    state_t state, next_state;

    logic [CW-1:0]  cnt;
    logic [W-1:0]   mag_a;
    logic [W-1:0]   mag_b;
    logic [2*W-1:0] acc;
    logic [W-1:0]   rem;
    logic           is_div;
    logic           neg_res;
    logic           neg_op1;

    logic           accept;
    logic           op_muldiv;
    logic           op_div;
    logic           op_signed;
    logic           sign1;
    logic           sign2;
    logic [W-1:0]   abs_op1;
    logic [W-1:0]   abs_op2;
    logic [W:0]     add_sum;
    logic [W:0]     rem_shift;
    logic [W:0]     rem_diff;
    logic [2*W-1:0] prod_fix;
    logic [W-1:0]   hi_fix;
    logic [W-1:0]   lo_fix;

    assign busy = (state != IDLE);

    always_comb begin
        accept    = (state == IDLE) && start && !flush;
        op_muldiv = (mdu_op >= 3'd1) && (mdu_op <= 3'd4);
        op_div    = (mdu_op == 3'd3) || (mdu_op == 3'd4);
        op_signed = (mdu_op == 3'd1) || (mdu_op == 3'd3);
        sign1     = op_signed && op1[W-1];
        sign2     = op_signed && op2[W-1];
        abs_op1   = sign1 ? -op1 : op1;
        abs_op2   = sign2 ? -op2 : op2;
    end

    // One iteration of each algorithm; the divide borrow shows up in bit W.
    always_comb begin
        add_sum   = {1'b0, acc[2*W-1:W]} + {1'b0, mag_a};
        rem_shift = {rem, acc[W-1]};
        rem_diff  = rem_shift - {1'b0, mag_b};
    end

    always_comb begin
        prod_fix = neg_res ? -acc : acc;
        hi_fix   = prod_fix[2*W-1:W];
        lo_fix   = prod_fix[W-1:0];
        if (is_div) begin
            if (mag_b == '0) begin
                lo_fix = '1;
                hi_fix = neg_op1 ? -mag_a : mag_a;
            end else begin
                lo_fix = neg_res ? -acc[W-1:0] : acc[W-1:0];
                hi_fix = neg_op1 ? -rem : rem;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE: if (accept && op_muldiv) next_state = RUN;
            RUN: begin
                if (flush) begin
                    next_state = IDLE;
                end else if (cnt == CW'(1)) begin
                    next_state = FIX;
                end
            end
            FIX:     next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Datapath: operand latch, per-step iteration and the final HI/LO write.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt     <= '0;
            mag_a   <= '0;
            mag_b   <= '0;
            acc     <= '0;
            rem     <= '0;
            is_div  <= 1'b0;
            neg_res <= 1'b0;
            neg_op1 <= 1'b0;
            done    <= 1'b0;
            hi      <= '0;
            lo      <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept && op_muldiv) begin
                        mag_a   <= abs_op1;
                        mag_b   <= abs_op2;
                        is_div  <= op_div;
                        neg_res <= sign1 ^ sign2;
                        neg_op1 <= sign1;
                        rem     <= '0;
                        cnt     <= CW'(STEPS);
                        acc     <= op_div ? {{W{1'b0}}, abs_op1} : {{W{1'b0}}, abs_op2};
                    end else if (accept && mdu_op == 3'd5) begin
                        hi <= op1;
                    end else if (accept && mdu_op == 3'd6) begin
                        lo <= op1;
                    end
                end
                RUN: begin
                    if (!flush) begin
                        cnt <= cnt - CW'(1);
                        if (is_div) begin
                            if (!rem_diff[W]) begin
                                rem <= rem_diff[W-1:0];
                                acc <= {acc[2*W-1:W], acc[W-2:0], 1'b1};
                            end else begin
                                rem <= rem_shift[W-1:0];
                                acc <= {acc[2*W-1:W], acc[W-2:0], 1'b0};
                            end
                        end else if (acc[0]) begin
                            acc <= {add_sum, acc[W-1:1]};
                        end else begin
                            acc <= {1'b0, acc[2*W-1:1]};
                        end
                    end
                end
                FIX: begin
                    if (!flush) begin
                        hi   <= hi_fix;
                        lo   <= lo_fix;
                        done <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mdu_ctrl.sv
// Self-checking bench for mdu_ctrl: directed and random MUL/DIV against a 64-bit
// arithmetic model, plus MTHI/MTLO, flush, ignored start and reset cases.
module tb_mdu_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        flush = 1'b0;
    logic [2:0]  mdu_op = 3'd0;
    logic [31:0] op1 = '0;
    logic [31:0] op2 = '0;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;

    int checks = 0;
    int errors = 0;

    mdu_ctrl #(.W(32), .STEPS(32)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .mdu_op(mdu_op),
        .op1(op1), .op2(op2), .flush(flush),
        .busy(busy), .done(done), .hi(hi), .lo(lo)
    );

    always #5 clk = ~clk;

    // Reference: plain 64-bit arithmetic; SV division truncates toward zero.
    function automatic void model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] mhi, output logic [31:0] mlo);
        longint sa, sb, q, r;
        logic [63:0] p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        mhi = '0;
        mlo = '0;
        case (op)
            3'd1: begin p = 64'(sa * sb); mhi = p[63:32]; mlo = p[31:0]; end
            3'd2: begin p = {32'd0, a} * {32'd0, b}; mhi = p[63:32]; mlo = p[31:0]; end
            3'd3: begin
                if (b == 0) begin mlo = '1; mhi = a; end
                else begin q = sa / sb; r = sa % sb; mlo = 32'(q); mhi = 32'(r); end
            end
            3'd4: begin
                if (b == 0) begin mlo = '1; mhi = a; end
                else begin mlo = a / b; mhi = a % b; end
            end
            default: ;
        endcase
    endfunction

    // Drives a one-cycle start from a negedge and returns after the done pulse (lat=-1 on timeout).
    task automatic do_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         output int lat, output logic [31:0] rhi, output logic [31:0] rlo);
        start = 1'b1; mdu_op = op; op1 = a; op2 = b;
        @(negedge clk);
        start = 1'b0; mdu_op = 3'($urandom_range(0, 7)); op1 = $urandom; op2 = $urandom;
        lat = -1;
        for (int n = 1; n <= 40; n++) begin
            @(negedge clk);
            if (done === 1'b1) begin lat = n; break; end
        end
        rhi = hi; rlo = lo;
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy got %0b exp 0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("[TB] FAIL reset_done got %0b exp 0", done); end
        checks++; if (hi !== 32'h0) begin errors++; $display("[TB] FAIL reset_hi got %h exp 0", hi); end
        checks++; if (lo !== 32'h0) begin errors++; $display("[TB] FAIL reset_lo got %h exp 0", lo); end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_multu_timing();
        logic [31:0] phi, plo;
        phi = hi; plo = lo;
        start = 1'b1; mdu_op = 3'd2; op1 = 32'hFFFFFFFF; op2 = 32'hFFFFFFFF;
        for (int e = 0; e <= 34; e++) begin
            @(negedge clk);
            if (e == 0) begin start = 1'b0; op1 = $urandom; op2 = $urandom; end
            checks++; if (busy !== (e <= 32)) begin errors++; $display("[TB] FAIL timing_busy edge %0d got %0b exp %0b", e, busy, e <= 32); end
            checks++; if (done !== (e == 33)) begin errors++; $display("[TB] FAIL timing_done edge %0d got %0b exp %0b", e, done, e == 33); end
            if (e < 33) begin
                checks++; if (hi !== phi || lo !== plo) begin errors++; $display("[TB] FAIL timing_hold edge %0d got %h_%h exp %h_%h", e, hi, lo, phi, plo); end
            end else begin
                checks++; if (hi !== 32'hFFFFFFFE || lo !== 32'h1) begin errors++; $display("[TB] FAIL timing_result edge %0d got %h_%h exp fffffffe_00000001", e, hi, lo); end
            end
        end
    endtask

    task automatic test_directed();
        logic [2:0]  ops [6] = '{3'd1, 3'd3, 3'd4, 3'd3, 3'd4, 3'd3};
        logic [31:0] as  [6] = '{32'hFFFFFFFD, 32'hFFFFFFF9, 32'd100, 32'h80000000, 32'h1234, 32'hFFFFFFFB};
        logic [31:0] bs  [6] = '{32'd7, 32'd2, 32'd7, 32'hFFFFFFFF, 32'd0, 32'd0};
        logic [31:0] ehi, elo, rhi, rlo;
        int lat;
        for (int i = 0; i < 6; i++) begin
            model(ops[i], as[i], bs[i], ehi, elo);
            do_op(ops[i], as[i], bs[i], lat, rhi, rlo);
            checks++; if (lat != 33) begin errors++; $display("[TB] FAIL directed_latency #%0d got %0d exp 33", i, lat); end
            checks++; if (rhi !== ehi || rlo !== elo) begin errors++; $display("[TB] FAIL directed_result #%0d op %0d got hi=%h lo=%h exp hi=%h lo=%h", i, ops[i], rhi, rlo, ehi, elo); end
        end
    endtask

    task automatic test_random();
        logic [2:0]  op;
        logic [31:0] a, b, ehi, elo, rhi, rlo;
        int lat;
        for (int i = 0; i < 24; i++) begin
            op = 3'($urandom_range(1, 4));
            a  = ($urandom_range(0, 5) == 0) ? 32'h80000000 : $urandom;
            case ($urandom_range(0, 7))
                0: b = 32'h0;
                1: b = 32'($urandom_range(1, 15));
                2: b = 32'hFFFFFFFF;
                default: b = $urandom;
            endcase
            model(op, a, b, ehi, elo);
            do_op(op, a, b, lat, rhi, rlo);
            checks++; if (lat != 33) begin errors++; $display("[TB] FAIL random_latency #%0d got %0d exp 33", i, lat); end
            checks++; if (rhi !== ehi || rlo !== elo) begin errors++; $display("[TB] FAIL random_result #%0d op %0d a=%h b=%h got %h_%h exp %h_%h", i, op, a, b, rhi, rlo, ehi, elo); end
        end
    endtask

    task automatic test_nop();
        logic [31:0] phi, plo;
        logic [2:0] nops [2] = '{3'd0, 3'd7};
        phi = hi; plo = lo;
        for (int i = 0; i < 2; i++) begin
            start = 1'b1; mdu_op = nops[i]; op1 = $urandom; op2 = $urandom;
            @(negedge clk);
            start = 1'b0;
            checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL nop_busy op %0d got %0b exp 0", nops[i], busy); end
            checks++; if (hi !== phi || lo !== plo) begin errors++; $display("[TB] FAIL nop_hold op %0d got %h_%h exp %h_%h", nops[i], hi, lo, phi, plo); end
        end
    endtask

    task automatic test_flush();
        logic [31:0] phi, plo;
        bit seen_done;
        phi = hi; plo = lo;
        start = 1'b1; mdu_op = 3'd2; op1 = 32'h11111111; op2 = 32'd3;
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL flush_run_busy got %0b exp 0", busy); end
        seen_done = 0;
        repeat (40) begin @(negedge clk); if (done === 1'b1) seen_done = 1; end
        checks++; if (seen_done) begin errors++; $display("[TB] FAIL flush_run_done got 1 exp 0"); end
        checks++; if (hi !== phi || lo !== plo) begin errors++; $display("[TB] FAIL flush_run_hold got %h_%h exp %h_%h", hi, lo, phi, plo); end

        start = 1'b1; mdu_op = 3'd4; op1 = 32'd1000; op2 = 32'd3;
        @(negedge clk);
        start = 1'b0;
        repeat (32) @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        checks++; if (busy !== 1'b0 || done !== 1'b0) begin errors++; $display("[TB] FAIL flush_fix_state got busy=%0b done=%0b exp 0 0", busy, done); end
        checks++; if (hi !== phi || lo !== plo) begin errors++; $display("[TB] FAIL flush_fix_hold got %h_%h exp %h_%h", hi, lo, phi, plo); end

        start = 1'b1; flush = 1'b1; mdu_op = 3'd5; op1 = 32'hDEADBEEF;
        @(negedge clk);
        mdu_op = 3'd3;
        @(negedge clk);
        start = 1'b0; flush = 1'b0;
        checks++; if (hi !== phi || busy !== 1'b0) begin errors++; $display("[TB] FAIL flush_idle got hi=%h busy=%0b exp hi=%h busy=0", hi, busy, phi); end
    endtask

    task automatic test_ignore_second_start();
        int lat;
        start = 1'b1; mdu_op = 3'd4; op1 = 32'd100; op2 = 32'd7;
        @(negedge clk);
        start = 1'b0; op1 = $urandom; op2 = $urandom;
        lat = -1;
        for (int n = 1; n <= 40; n++) begin
            @(negedge clk);
            if (n == 5) begin start = 1'b1; mdu_op = 3'd2; op1 = $urandom; op2 = $urandom; end
            if (n == 6) start = 1'b0;
            if (done === 1'b1) begin lat = n; break; end
        end
        checks++; if (lat != 33) begin errors++; $display("[TB] FAIL second_start_latency got %0d exp 33", lat); end
        checks++; if (lo !== 32'd14 || hi !== 32'd2) begin errors++; $display("[TB] FAIL second_start_result got %h_%h exp 00000002_0000000e", hi, lo); end
        @(negedge clk);
        checks++; if (done !== 1'b0 || busy !== 1'b0) begin errors++; $display("[TB] FAIL second_start_after got done=%0b busy=%0b exp 0 0", done, busy); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] ehi, elo, rhi, rlo;
        int lat;
        start = 1'b1; mdu_op = 3'd5; op1 = 32'hCAFEBABE;
        @(negedge clk);
        mdu_op = 3'd6; op1 = 32'h12345678;
        checks++; if (hi !== 32'hCAFEBABE || busy !== 1'b0) begin errors++; $display("[TB] FAIL mthi got hi=%h busy=%0b exp cafebabe 0", hi, busy); end
        @(negedge clk);
        start = 1'b0;
        checks++; if (lo !== 32'h12345678 || busy !== 1'b0 || done !== 1'b0) begin errors++; $display("[TB] FAIL mtlo got lo=%h busy=%0b done=%0b exp 12345678 0 0", lo, busy, done); end

        do_op(3'd1, 32'hFFFFFFF0, 32'd9, lat, rhi, rlo);
        model(3'd4, 32'hABCDEF01, 32'd13, ehi, elo);
        do_op(3'd4, 32'hABCDEF01, 32'd13, lat, rhi, rlo);
        checks++; if (lat != 33) begin errors++; $display("[TB] FAIL start_on_done_latency got %0d exp 33", lat); end
        checks++; if (rhi !== ehi || rlo !== elo) begin errors++; $display("[TB] FAIL start_on_done_result got %h_%h exp %h_%h", rhi, rlo, ehi, elo); end

        start = 1'b1; mdu_op = 3'd1; op1 = $urandom; op2 = $urandom;
        @(negedge clk);
        start = 1'b0;
        repeat (10) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        checks++; if (hi !== 32'h0 || lo !== 32'h0 || busy !== 1'b0 || done !== 1'b0) begin errors++; $display("[TB] FAIL reset_mid_run got hi=%h lo=%h busy=%0b done=%0b exp 0 0 0 0", hi, lo, busy, done); end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_discard got busy=%0b exp 0", busy); end
    endtask

    initial begin
        test_reset();
        test_multu_timing();
        test_directed();
        test_random();
        test_nop();
        test_flush();
        test_ignore_second_start();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
